// File: rtl/alu_seq.sv
// alu_seq: sequenced ALU. Single-cycle logic/arith/shift/compare operations
// return one edge after start. Multiply (shift-add) and divide (restoring)
// take one operand bit per cycle and return Nbits edges after the start edge.
//
// Ports:
//   clk     - clock, rising edge active
//   reset   - asynchronous, active-high reset
//   start   - accept inA/inB/selOp this cycle (ignored while busy)
//   inA     - operand A
//   inB     - operand B
//   selOp   - operation select
//   busy    - multi-cycle operation in progress
//   done    - one-cycle pulse: result/zero newly valid
//   result  - registered result, held between done pulses
//   zero    - registered (result == 0)
//
// State | meaning
// IDLE  | waiting for start; single-cycle ops complete here
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle

module alu_seq #(
    parameter int Nbits = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [Nbits-1:0] inA,
    input  logic [Nbits-1:0] inB,
    input  logic [3:0]       selOp,
    output logic             busy,
    output logic             done,
    output logic [Nbits-1:0] result,
    output logic             zero
);

    localparam int CW = $clog2(Nbits);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    // MUL: {product high, multiplier/product low}
    // DIV: {partial remainder, dividend/quotient}
    logic [2*Nbits-1:0]   work_q, work_d;
    logic [Nbits-1:0]     b_q, b_d;
    // selects the upper half of work as the final result (MULHU, REMU)
    logic                 hi_q, hi_d;
    logic [Nbits-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 done_q, done_d;

    logic [CW-1:0]        shamt;
    logic [Nbits-1:0]     alu_res;
    logic [Nbits:0]       mul_sum;
    logic [2*Nbits-1:0]   mul_next;
    logic [Nbits:0]       div_shift;
    logic [Nbits:0]       div_diff;
    logic                 div_ge;
    logic [Nbits-1:0]     div_rem;
    logic [2*Nbits-1:0]   div_next;
    logic [2*Nbits-1:0]   iter_next;
    logic [Nbits-1:0]     fin_val;

    assign shamt = inB[CW-1:0];

    always_comb begin
        alu_res = inA;
        case (selOp)
            OP_AND:  alu_res = inA & inB;
            OP_OR:   alu_res = inA | inB;
            OP_ADD:  alu_res = inA + inB;
            OP_SUB:  alu_res = inA - inB;
            OP_XOR:  alu_res = inA ^ inB;
            OP_SLL:  alu_res = inA << shamt;
            OP_SRL:  alu_res = inA >> shamt;
            OP_SRA:  alu_res = $signed(inA) >>> shamt;
            OP_SLT:  alu_res = {{(Nbits-1){1'b0}}, ($signed(inA) < $signed(inB))};
            OP_SLTU: alu_res = {{(Nbits-1){1'b0}}, (inA < inB)};
            default: alu_res = inA;
        endcase
    end

    // Shift-add step: add multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole product right by one.
    always_comb begin
        mul_sum  = {1'b0, work_q[2*Nbits-1:Nbits]} + {1'b0, (work_q[0] ? b_q : '0)};
        mul_next = {mul_sum, work_q[Nbits-1:1]};
    end

    // Restoring step: shift the next dividend bit into the remainder and keep
    // the difference only if it did not go negative. A zero divisor always
    // subtracts, which yields an all-ones quotient and remainder = dividend.
    always_comb begin
        div_shift = {work_q[2*Nbits-1:Nbits], work_q[Nbits-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_rem   = div_ge ? div_diff[Nbits-1:0] : div_shift[Nbits-1:0];
        div_next  = {div_rem, work_q[Nbits-2:0], div_ge};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        b_d       = b_q;
        hi_d      = hi_q;
        result_d  = result_q;
        zero_d    = zero_q;
        done_d    = 1'b0;
        iter_next = (state_q == MUL) ? mul_next : div_next;
        fin_val   = hi_q ? iter_next[2*Nbits-1:Nbits] : iter_next[Nbits-1:0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (selOp)
                        OP_MUL, OP_MULHU: begin
                            state_d = MUL;
                            work_d  = {{Nbits{1'b0}}, inA};
                            b_d     = inB;
                            hi_d    = (selOp == OP_MULHU);
                            cnt_d   = '0;
                        end
                        OP_DIVU, OP_REMU: begin
                            state_d = DIV;
                            work_d  = {{Nbits{1'b0}}, inA};
                            b_d     = inB;
                            hi_d    = (selOp == OP_REMU);
                            cnt_d   = '0;
                        end
                        default: begin
                            result_d = alu_res;
                            zero_d   = (alu_res == '0);
                            done_d   = 1'b1;
                        end
                    endcase
                end
            end
            MUL, DIV: begin
                work_d = iter_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(Nbits-1)) begin
                    result_d = fin_val;
                    zero_d   = (fin_val == '0);
                    done_d   = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            b_q      <= '0;
            hi_q     <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    logic        clk;
    logic        reset;

    logic        start64;
    logic [63:0] a64, b64;
    logic [3:0]  op64;
    logic        busy64, done64, zero64;
    logic [63:0] res64;

    logic        start8;
    logic [7:0]  a8, b8;
    logic [3:0]  op8;
    logic        busy8, done8, zero8;
    logic [7:0]  res8;

    int checks;
    int errors;

    alu_seq #(.Nbits(64)) u_alu64 (
        .clk(clk), .reset(reset), .start(start64), .inA(a64), .inB(b64),
        .selOp(op64), .busy(busy64), .done(done64), .result(res64), .zero(zero64)
    );

    alu_seq #(.Nbits(8)) u_alu8 (
        .clk(clk), .reset(reset), .start(start8), .inA(a8), .inB(b8),
        .selOp(op8), .busy(busy8), .done(done8), .result(res8), .zero(zero8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one 8-bit op and waits (bounded) for done. lat counts edges from
    // the start edge (start edge = 1); busy_cnt counts sampled busy cycles
    // before done; busy_at_done is busy in the done cycle.
    task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic [7:0] res, output int busy_cnt,
                          output logic busy_at_done);
        op8 = op; a8 = a; b8 = b; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!done8 && lat < 30) begin
            if (busy8) busy_cnt++;
            tick();
            lat++;
        end
        res = res8;
        busy_at_done = busy8;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL reset_busy64 got %b exp 0", busy64); end
        checks++; if (done64 !== 1'b0) begin errors++; $display("FAIL reset_done64 got %b exp 0", done64); end
        checks++; if (res64 !== 64'd0) begin errors++; $display("FAIL reset_result64 got %h exp 0", res64); end
        checks++; if (zero64 !== 1'b1) begin errors++; $display("FAIL reset_zero64 got %b exp 1", zero64); end
        checks++; if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 8'd0 || zero8 !== 1'b1) begin
            errors++; $display("FAIL reset_8 got busy=%b done=%b res=%h zero=%b exp 0 0 00 1", busy8, done8, res8, zero8);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single64();
        logic [3:0]  ops [12];
        logic [63:0] va  [12];
        logic [63:0] vb  [12];
        logic [63:0] ve  [12];
        ops = '{4'b0010, 4'b0111, 4'b0110, 4'b1000, 4'b1001, 4'b0100,
                4'b0101, 4'b0000, 4'b0001, 4'b0011, 4'b1111, 4'b0010};
        va  = '{64'd5, 64'h8000_0000_0000_0000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 64'hF0F0,
                64'hF0F0, 64'hFFFF, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF};
        vb  = '{64'hFFFF_FFFF_FFFF_FFFB, 64'h44, 64'd5, 64'd1, 64'd1, 64'h141,
                64'h3F, 64'hFF00, 64'h0F0F, 64'h00FF, 64'd5, 64'd2};
        ve  = '{64'd0, 64'hF800_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1,
                64'd0, 64'd2, 64'd1, 64'hF000, 64'hFFFF, 64'hFF00, 64'h1234, 64'd1};
        for (int i = 0; i < 12; i++) begin
            op64 = ops[i]; a64 = va[i]; b64 = vb[i]; start64 = 1'b1;
            tick();
            start64 = 1'b0;
            checks++; if (res64 !== ve[i]) begin errors++; $display("FAIL single64_result[%0d] got %h exp %h", i, res64, ve[i]); end
            checks++; if (done64 !== 1'b1 || busy64 !== 1'b0 || zero64 !== (ve[i] == 64'd0)) begin
                errors++; $display("FAIL single64_flags[%0d] got done=%b busy=%b zero=%b exp 1 0 %b", i, done64, busy64, zero64, (ve[i] == 64'd0));
            end
            a64 = 64'hDEAD; b64 = 64'hBEEF;
            tick();
            checks++; if (done64 !== 1'b0 || res64 !== ve[i]) begin
                errors++; $display("FAIL single64_hold[%0d] got done=%b res=%h exp 0 %h", i, done64, res64, ve[i]);
            end
        end
    endtask

    task automatic test_mul8();
        int lat, bc;
        logic [7:0] r;
        logic bd;
        issue8(4'b1011, 8'hFF, 8'hFF, lat, r, bc, bd);
        checks++; if (r !== 8'hFE) begin errors++; $display("FAIL mulhu_result got %h exp fe", r); end
        checks++; if (lat !== 9 || bc !== 8 || bd !== 1'b0) begin
            errors++; $display("FAIL mulhu_timing got lat=%0d busy=%0d busy_at_done=%b exp 9 8 0", lat, bc, bd);
        end
        issue8(4'b1010, 8'hFF, 8'hFF, lat, r, bc, bd);
        checks++; if (r !== 8'h01 || lat !== 9) begin errors++; $display("FAIL mul_result got %h lat=%0d exp 01 9", r, lat); end
        issue8(4'b1010, 8'd13, 8'd11, lat, r, bc, bd);
        checks++; if (r !== 8'h8F || zero8 !== 1'b0) begin errors++; $display("FAIL mul_13x11 got %h zero=%b exp 8f 0", r, zero8); end
        issue8(4'b1000, 8'h80, 8'h01, lat, r, bc, bd);
        checks++; if (r !== 8'h01 || lat !== 1 || bc !== 0) begin
            errors++; $display("FAIL slt8 got %h lat=%0d busy=%0d exp 01 1 0", r, lat, bc);
        end
    endtask

    task automatic test_div8();
        int lat, bc, dcnt;
        logic [7:0] r;
        logic bd;
        issue8(4'b1100, 8'd200, 8'd0, lat, r, bc, bd);
        checks++; if (r !== 8'hFF || lat !== 9) begin errors++; $display("FAIL divu_by0 got %h lat=%0d exp ff 9", r, lat); end
        issue8(4'b1101, 8'd200, 8'd0, lat, r, bc, bd);
        checks++; if (r !== 8'd200 || lat !== 9) begin errors++; $display("FAIL remu_by0 got %0d lat=%0d exp 200 9", r, lat); end
        issue8(4'b1100, 8'd3, 8'd7, lat, r, bc, bd);
        checks++; if (r !== 8'd0 || zero8 !== 1'b1) begin errors++; $display("FAIL divu_zero got %0d zero=%b exp 0 1", r, zero8); end
        // start pulsed with different operands while busy must be ignored
        op8 = 4'b1100; a8 = 8'd100; b8 = 8'd7; start8 = 1'b1;
        tick();
        op8 = 4'b0010; a8 = 8'd1; b8 = 8'd1;
        tick();
        start8 = 1'b0;
        op8 = 4'b1101; a8 = 8'd55; b8 = 8'd3;
        lat = 2;
        dcnt = 0;
        while (!done8 && lat < 30) begin tick(); lat++; end
        r = res8;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done8) dcnt++;
        end
        checks++; if (r !== 8'd14 || lat !== 9) begin errors++; $display("FAIL div_ignore_start got %0d lat=%0d exp 14 9", r, lat); end
        checks++; if (dcnt !== 0 || res8 !== 8'd14) begin errors++; $display("FAIL div_single_done got extra=%0d res=%0d exp 0 14", dcnt, res8); end
    endtask

    task automatic test_reset_mid();
        int dcnt, lat, bc;
        logic [7:0] r;
        logic bd;
        op8 = 4'b1100; a8 = 8'd100; b8 = 8'd7; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        checks++; if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 8'd0 || zero8 !== 1'b1) begin
            errors++; $display("FAIL reset_mid got busy=%b done=%b res=%h zero=%b exp 0 0 00 1", busy8, done8, res8, zero8);
        end
        tick();
        reset = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done8 || busy8) dcnt++;
        end
        checks++; if (dcnt !== 0) begin errors++; $display("FAIL reset_abort got activity=%0d exp 0", dcnt); end
        issue8(4'b1101, 8'd100, 8'd7, lat, r, bc, bd);
        checks++; if (r !== 8'd2 || lat !== 9) begin errors++; $display("FAIL after_reset got %0d lat=%0d exp 2 9", r, lat); end
    endtask

    task automatic test_back_to_back();
        int lat, gap;
        logic [7:0] r1, r2;
        op8 = 4'b1100; a8 = 8'd100; b8 = 8'd7; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 30) begin tick(); lat++; end
        r1 = res8;
        checks++; if (r1 !== 8'd14 || lat !== 9) begin errors++; $display("FAIL b2b_first got %0d lat=%0d exp 14 9", r1, lat); end
        op8 = 4'b1101; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        gap = 1;
        checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b exp 1", busy8); end
        while (!done8 && gap < 30) begin tick(); gap++; end
        r2 = res8;
        checks++; if (r2 !== 8'd2 || gap !== 9) begin errors++; $display("FAIL b2b_second got %0d gap=%0d exp 2 9", r2, gap); end
    endtask

    initial begin
        checks = 0; errors = 0;
        start64 = 1'b0; a64 = '0; b64 = '0; op64 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
        reset = 1'b0;
        test_reset();
        test_single64();
        test_mul8();
        test_div8();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
